// File: rtl/alu_slice_sequencer.sv
// alu_slice_sequencer: runs a WIDTH-bit bitwise logic op through a SLICE-bit
// combinational slice unit, one slice per clock, least-significant slice first.
module alu_slice_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [1:0]       slice_op,
    output logic [SLICE-1:0] slice_x,
    output logic [SLICE-1:0] slice_y,
    input  logic [SLICE-1:0] slice_f
);

    localparam int unsigned NSLICES = WIDTH / SLICE;
    localparam int unsigned IDX_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_acc;
    logic               w_last;

    assign w_last = (r_idx == LAST_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: accept in IDLE, walk all slices in RUN, one DONE cycle
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_next_state = S_RUN;
            S_RUN:   if (w_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output decode: handshake flags and slice-unit drive (zero outside RUN)
    always_comb begin
        ready    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        slice_op = 2'b00;
        slice_x  = '0;
        slice_y  = '0;
        case (r_state)
            S_IDLE: ready = 1'b1;
            S_RUN: begin
                busy     = 1'b1;
                slice_op = r_op;
                slice_x  = r_a[r_idx*SLICE +: SLICE];
                slice_y  = r_b[r_idx*SLICE +: SLICE];
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand latch, per-slice accumulation, result/zero publish
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_op   <= 2'b00;
            r_acc  <= '0;
            result <= '0;
            zero   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_op  <= op;
                        r_idx <= '0;
                        r_acc <= '0;
                    end
                end
                S_RUN: begin
                    r_acc[r_idx*SLICE +: SLICE] <= slice_f;
                    if (!w_last) begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    result <= r_acc;
                    zero   <= (r_acc == '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Directed bench for alu_slice_sequencer with a combinational slice model and
// a result scoreboard fed at each accepted start.
module tb_alu_slice_sequencer;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned SLICE = 4;

    logic             clk;
    logic             reset;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [1:0]       slice_op;
    logic [SLICE-1:0] slice_x;
    logic [SLICE-1:0] slice_y;
    logic [SLICE-1:0] slice_f;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             z;
    } exp_t;

    exp_t exp_q[$];
    exp_t pend;
    bit   pend_valid = 0;

    alu_slice_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .slice_op (slice_op),
        .slice_x  (slice_x),
        .slice_y  (slice_y),
        .slice_f  (slice_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] model_word(input logic [1:0] o,
                                                    input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y);
        case (o)
            2'b00:   return x | y;
            2'b01:   return x & y;
            2'b10:   return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    // Combinational slice unit model
    always_comb begin
        case (slice_op)
            2'b00:   slice_f = slice_x | slice_y;
            2'b01:   slice_f = slice_x & slice_y;
            2'b10:   slice_f = slice_x ^ slice_y;
            default: slice_f = ~(slice_x | slice_y);
        endcase
    end

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Scoreboard push on every accepted start; flush on reset
    always @(posedge clk) begin
        exp_t e;
        if (reset) begin
            exp_q.delete();
        end else if (start && ready) begin
            e.res = model_word(op, a, b);
            e.z   = (e.res == '0);
            exp_q.push_back(e);
        end
    end

    // Scoreboard pop on done; result/zero compared one cycle later
    always @(negedge clk) begin
        if (pend_valid) begin
            check("sb_result", result, pend.res);
            check("sb_zero", 32'(zero), 32'(pend.z));
            pend_valid = 0;
        end
        if (done && !reset) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_done", 32'(done), 32'd0);
            end else begin
                pend       = exp_q.pop_front();
                pend_valid = 1;
            end
        end
    end

    // Run one op from IDLE with cycle-exact checks; noisy mode toggles inputs during RUN/DONE
    task automatic run_op(input logic [1:0] o, input logic [WIDTH-1:0] x,
                          input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] expr,
                          input bit noisy);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("run%0d_busy", i), 32'(busy), 32'd1);
            check($sformatf("run%0d_ready", i), 32'(ready), 32'd0);
            check($sformatf("run%0d_done", i), 32'(done), 32'd0);
            check($sformatf("run%0d_slice_x", i), 32'(slice_x), 32'((x >> (4*i)) & 32'hF));
            check($sformatf("run%0d_slice_y", i), 32'(slice_y), 32'((y >> (4*i)) & 32'hF));
            check($sformatf("run%0d_slice_op", i), 32'(slice_op), 32'(o));
            if (noisy) begin
                start = 1'b1; a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
            end
            @(negedge clk);
        end
        check("done_pulse", 32'(done), 32'd1);
        check("done_ready", 32'(ready), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        check("done_slice_x", 32'(slice_x), 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("idle_ready", 32'(ready), 32'd1);
        check("idle_done", 32'(done), 32'd0);
        check("final_result", result, expr);
        check("final_zero", 32'(zero), 32'(expr == '0));
    endtask

    int done_cnt;
    int done_at[$];
    int overlap;
    bit prev_done;

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'h0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_slice_x", 32'(slice_x), 32'd0);
        check("rst_slice_y", 32'(slice_y), 32'd0);
        check("rst_slice_op", 32'(slice_op), 32'd0);

        run_op(2'b00, 32'h0000_9009, 32'h0000_3003, 32'h0000_B00B, 0);
        run_op(2'b01, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000, 0);
        run_op(2'b10, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000, 0);
        run_op(2'b11, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 0);

        // Start and operand churn during RUN/DONE must be ignored
        run_op(2'b00, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1);
        repeat (3) begin
            @(negedge clk);
            check("no_second_op_ready", 32'(ready), 32'd1);
            check("no_second_op_busy", 32'(busy), 32'd0);
        end

        // Abort mid-RUN after a prior result
        run_op(2'b00, 32'h0000_9009, 32'h0000_3003, 32'h0000_B00B, 0);
        start = 1'b1; op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", result, 32'h0);
        check("abort_zero", 32'(zero), 32'd1);
        done_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        run_op(2'b00, 32'h0000_0010, 32'h0000_0001, 32'h0000_0011, 0);

        // Back-to-back with start held high
        start = 1'b1; op = 2'b10; a = 32'h1234_5678; b = 32'h0F0F_F0F0;
        overlap = 0; prev_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done && ready) overlap++;
            if (done && prev_done) overlap++;
            if (done) done_at.push_back(k);
            prev_done = done;
        end
        start = 1'b0;
        check("b2b_overlap", 32'(overlap), 32'd0);
        check("b2b_done_count", 32'(done_at.size()), 32'd4);
        if (done_at.size() == 4) begin
            check("b2b_first_done", 32'(done_at[0]), 32'd8);
            for (int j = 1; j < 4; j++)
                check($sformatf("b2b_interval%0d", j), 32'(done_at[j] - done_at[j-1]), 32'd10);
        end
        repeat (3) @(negedge clk);
        check("b2b_idle", 32'(ready), 32'd1);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
